// File: rtl/shift_reg_sipo_rx.sv
// shift_reg_sipo_rx -- serial-in/parallel-out frame receiver (MSB first).
//
// Samples sdi on cycles where sdi_valid=1 and aligns frames on sof. Each
// completed WIDTH-bit word is committed into a valid/ready holding register.
// The first bit received lands in dout[WIDTH-1].
//
// Optional build macro: SIPO_PARITY_EN
//   When defined, each frame carries one trailing even-parity bit. The word
//   commits on that bit, and parity_err is loaded alongside dout. When the
//   macro is undefined, frames are WIDTH bits and parity_err is tied 0.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   sdi          serial data in, MSB first
//   sdi_valid    bit qualifier; sdi sampled only when 1
//   sof          start-of-frame; marks the current qualified bit as bit 0
//   dout         received word, stable while dout_valid=1
//   dout_valid   word available
//   dout_ready   downstream accept (transfer on dout_valid && dout_ready)
//   overrun      sticky: a completed word was dropped
//   frame_abort  one-cycle pulse: sof arrived mid-frame
//   parity_err   parity check result for the word on dout
module shift_reg_sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdi,
    input  logic             sdi_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             frame_abort,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH);

    // Without parity the last data bit is taken straight from sdi, so only
    // WIDTH-1 earlier bits need storage. With parity the full word is held
    // while the parity bit is awaited.
`ifdef SIPO_PARITY_EN
    localparam int SW = WIDTH;
`else
    localparam int SW = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef SIPO_PARITY_EN
        , PAR
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_abort_q, frame_abort_d;
    logic              commit;
    logic [WIDTH-1:0]  word;
`ifdef SIPO_PARITY_EN
    logic              parity_err_q, parity_err_d;
    logic              commit_perr;
`endif

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        dout_d        = dout_q;
        dout_valid_d  = dout_valid_q;
        overrun_d     = overrun_q;
        frame_abort_d = 1'b0;
        commit        = 1'b0;
`ifdef SIPO_PARITY_EN
        parity_err_d  = parity_err_q;
        commit_perr   = 1'b0;
        word          = shreg_q;
`else
        word          = {shreg_q, sdi};
`endif

        if (sdi_valid) begin
            if (sof) begin
                // sof always wins: any partial frame is dropped and this
                // bit becomes bit 0 of a fresh frame.
                frame_abort_d = (state_q != IDLE);
                shreg_d       = SW'(sdi);
                cnt_d         = CW'(1);
                state_d       = SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        shreg_d = SW'({shreg_q, sdi});
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d = '0;
`ifdef SIPO_PARITY_EN
                            state_d = PAR;
`else
                            state_d = IDLE;
                            commit  = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PAR: begin
                        state_d     = IDLE;
                        commit      = 1'b1;
                        commit_perr = ^{shreg_q, sdi};
                    end
`endif
                    default: ;
                endcase
            end
        end

        // Holding register: a commit into a full, stalled slot is dropped;
        // a commit into a slot being drained replaces it without a bubble.
        if (commit) begin
            if (dout_valid_q && !dout_ready) begin
                overrun_d = 1'b1;
            end else begin
                dout_d       = word;
                dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err_d = commit_perr;
`endif
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            frame_abort_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            overrun_q     <= overrun_d;
            frame_abort_q <= frame_abort_d;
`ifdef SIPO_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign overrun     = overrun_q;
    assign frame_abort = frame_abort_q;
`ifdef SIPO_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Testbench for shift_reg_sipo_rx: directed scenarios plus randomized
// traffic, checked every cycle against a frame-level reference model.
module tb_shift_reg_sipo_rx;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sdi = 1'b0;
    logic         sdi_valid = 1'b0;
    logic         sof = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         overrun;
    logic         frame_abort;
    logic         parity_err;

    shift_reg_sipo_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sdi         (sdi),
        .sdi_valid   (sdi_valid),
        .sof         (sof),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .frame_abort (frame_abort),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of bits seen since sof.
    bit          frame[$];
    bit          m_in_frame = 0;
    bit          m_valid = 0;
    int unsigned m_dout = 0;
    bit          m_ovr = 0;
    bit          m_abort = 0;
    bit          m_perr = 0;

    task automatic model_step();
        bit          accept;
        int unsigned w;
        int unsigned ones;
        if (reset) begin
            frame.delete();
            m_in_frame = 0;
            m_valid    = 0;
            m_dout     = 0;
            m_ovr      = 0;
            m_abort    = 0;
            m_perr     = 0;
            return;
        end
        accept  = m_valid && dout_ready;
        m_abort = 0;
        if (sdi_valid) begin
            if (sof) begin
                m_abort = m_in_frame;
                frame.delete();
                frame.push_back(sdi);
                m_in_frame = 1;
            end else if (m_in_frame) begin
                frame.push_back(sdi);
            end
        end
        if (m_in_frame && frame.size() == FLEN) begin
            w = 0;
            ones = 0;
            for (int unsigned i = 0; i < FLEN; i++) begin
                if (i < W) w = w * 2 + frame[i];
                ones += frame[i];
            end
            m_in_frame = 0;
            frame.delete();
            if (m_valid && !dout_ready) begin
                m_ovr = 1;
            end else begin
                m_dout  = w;
                m_valid = 1;
`ifdef SIPO_PARITY_EN
                m_perr  = (ones % 2) != 0;
`endif
            end
        end else if (accept) begin
            m_valid = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic s, input logic d, input logic rdy);
        reset      = r;
        sdi_valid  = v;
        sof        = s;
        sdi        = d;
        dout_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check("dout_valid", dout_valid, m_valid);
        check("dout", dout, m_dout);
        check("overrun", overrun, m_ovr);
        check("frame_abort", frame_abort, m_abort);
        check("parity_err", parity_err, m_perr);
    endtask

    task automatic idle(input logic rdy);
        cyc(0, 0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), rdy);
    endtask

    // Sends the low n bits of 'bits', MSB first, sof on the first one.
    task automatic send(input logic [7:0] bits, input int n, input int gap, input logic rdy);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, (i == 0), bits[n-1-i], rdy);
            if (i < n - 1)
                for (int g = 0; g < gap; g++) idle(rdy);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_overrun", overrun, 0);

`ifndef SIPO_PARITY_EN
        // single frame
        send(8'b0101, 4, 0, 1);
        check("t1_dout", dout, 4'b0101);
        check("t1_valid", dout_valid, 1);
        check("t1_ovr", overrun, 0);
        idle(1);
        check("t1_valid_drop", dout_valid, 0);

        // qualifier gaps
        send(8'b1101, 4, 2, 1);
        check("t2_dout", dout, 4'b1101);
        check("t2_valid", dout_valid, 1);
        idle(1);

        // overrun
        send(8'b1010, 4, 0, 0);
        send(8'b0011, 4, 0, 0);
        check("t3_dout", dout, 4'b1010);
        check("t3_valid", dout_valid, 1);
        check("t3_ovr", overrun, 1);
        idle(1);
        check("t3_drain", dout_valid, 0);

        // mid-frame sof
        cyc(0, 1, 1, 1, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 1, 0, 1);
        check("t4_abort", frame_abort, 1);
        cyc(0, 1, 0, 0, 1);
        check("t4_abort_clr", frame_abort, 0);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 1);
        check("t4_dout", dout, 4'b0010);
        check("t4_valid", dout_valid, 1);

        // reset mid-frame
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        check("t5_rst_ovr", overrun, 0);
        send(8'b1111, 4, 0, 1);
        check("t5_dout", dout, 4'b1111);
        check("t5_ovr", overrun, 0);
        idle(1);
`else
        send(8'b01010, 5, 0, 1);
        check("t6_dout_a", dout, 4'b0101);
        check("t6_perr_a", parity_err, 0);
        check("t6_valid_a", dout_valid, 1);
        send(8'b01110, 5, 0, 1);
        check("t6_dout_b", dout, 4'b0111);
        check("t6_perr_b", parity_err, 1);
        idle(1);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic v;
            v = ($urandom_range(0, 9) < 7);
            cyc(($urandom_range(0, 299) == 0), v,
                (v && $urandom_range(0, 5) == 0),
                logic'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_sipo_rx.md
Name: shift_reg_sipo_rx

Overview:
- Serial-in/parallel-out frame receiver; the receive end of the team's MSB-first PISO serial link.
- Samples `sdi` on qualified clock edges and aligns frames on a start-of-frame marker.
- Assembles WIDTH-bit words and presents each word through a valid/ready holding register to downstream logic.
- Flags overruns and aborted frames.

Parameters:
WIDTH, 4, data bits per frame (min 2); first bit received lands in dout[WIDTH-1].

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
sdi  input  1  serial data in, MSB first.
sdi_valid  input  1  bit qualifier; sdi sampled only when 1.
sof  input  1  start-of-frame; meaningful only with sdi_valid=1; marks the current bit as frame bit 0.
dout  output  WIDTH  received word, stable while dout_valid=1.
dout_valid  output  1  word available.
dout_ready  input  1  downstream accept; transfer when dout_valid && dout_ready.
overrun  output  1  sticky: a completed word was dropped.
frame_abort  output  1  one-cycle pulse: sof arrived mid-frame.
parity_err  output  1  see Optional Feature; tied 0 when the feature is out.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Reset, sampled on posedge clk:
  - FSM -> IDLE; shift register, bit counter and dout cleared to 0.
  - dout_valid, overrun, frame_abort and parity_err all cleared to 0.
  - A reset mid-frame discards the partial word; a held word is lost.
- FSM states: IDLE, SHIFT, PAR (PAR exists only with the feature).
- IDLE:
  - sdi_valid && sof -> shift in sdi, cnt=1, go to SHIFT.
  - sdi_valid without sof -> bit ignored, stay in IDLE.
- SHIFT, on each sdi_valid: shreg <= {shreg[WIDTH-2:0], sdi}; cnt++.
- Frame completion is the bit with cnt==WIDTH-1 before the increment.
  - Without the feature: go to IDLE and commit the word.
  - With the feature: go to PAR.
- sdi_valid=0 freezes state and counter; there is no timeout.
- sof && sdi_valid in SHIFT or PAR:
  - frame_abort pulses for 1 cycle; the partial frame is discarded.
  - The sof bit starts a new frame: cnt=1, state SHIFT.
- Commit:
  - The word appears on dout with dout_valid=1 on the clock edge that samples the last bit.
  - Latency: 1 cycle from last-bit sampling to visible output.
- Holding register:
  - dout_valid clears on dout_valid && dout_ready unless a commit occurs in the same cycle.
  - Commit while dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, overrun <= 1.
  - Commit while dout_valid=1 and dout_ready=1: the new word is loaded and dout_valid stays 1 (no bubble, no overrun).
- overrun clears only on reset.
- Back-to-back frames: sof may be asserted on the bit immediately after a frame's last bit. Full throughput is one word per WIDTH qualified bits.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame carries one extra bit after the data bits; the FSM enters PAR after the last data bit.
  - The next sdi_valid bit is the even-parity bit (XOR of data bits and parity bit = 0).
  - Commit happens on the parity bit. parity_err is loaded with the parity check result alongside dout and is valid while dout_valid=1.
  - A word with bad parity is still delivered.
  - parity_err holds with dout; it is not updated by a dropped (overrun) word.
- Undefined:
  - No PAR state; frames are WIDTH bits.
  - parity_err is constant 0.

Test Plan:
1. WIDTH=4, no parity. Reset, then bits 0,1,0,1 on consecutive cycles with sof on the first and dout_ready=1 -> after the edge sampling the 4th bit, dout=4'b0101 and dout_valid=1 for 1 cycle; overrun=0.
2. sdi_valid gaps: bits 1,1,0,1 with 2 idle cycles between each -> dout=4'b1101 one cycle after the 4th qualified bit; no output during the gaps.
3. Overrun, dout_ready=0:
   - Frame 1: 4'b1010 then frame 2: 4'b0011 -> dout stays 4'b1010, dout_valid=1, overrun=1.
   - Then dout_ready=1 -> dout_valid=0 next cycle.
4. Mid-frame sof: bits 1,1 then sof with bits 0,0,1,0 -> frame_abort pulses once, dout=4'b0010.
5. Reset mid-frame: after 2 bits assert reset 1 cycle, then a full frame 4'b1111 -> dout=4'b1111; no stale bits; overrun=0.
6. SIPO_PARITY_EN, WIDTH=4:
   - Data 0101 with parity 0 -> dout=4'b0101, parity_err=0.
   - Data 0111 with parity 0 -> parity_err=1, dout=4'b0111.
